// File: rtl/io_controller.sv
// io_controller: stalls the CPU while an IN/OUT instruction completes a
// valid/ready handshake with its device. It abandons a silent transaction
// after TIMEOUT_CYCLES wait cycles and raises a sticky error flag.
module io_controller #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        i_CLK,
  input  logic        i_RESET_N,
  input  logic        i_IOPAUSE,
  input  logic        i_IOTYPE,
  input  logic [15:0] i_OUTDATA,
  output logic        o_STALL,
  output logic        o_REGWRITE_EN,
  output logic [15:0] o_INDATA,
  output logic        o_OUT_VALID,
  output logic [15:0] o_OUT_DATA,
  input  logic        i_OUT_READY,
  input  logic        i_IN_VALID,
  input  logic [15:0] i_IN_DATA,
  output logic        o_IN_READY,
  output logic        o_TIMEOUT,
  input  logic        i_CLRERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OUT_WAIT,
    S_IN_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] wait_cnt;
  logic        in_wait;
  logic        handshake;
  logic        wait_last;
  logic        expire;

  // Handshake and timeout detection for the current WAIT cycle.
  always_comb begin
    in_wait   = (state == S_OUT_WAIT) || (state == S_IN_WAIT);
    handshake = ((state == S_OUT_WAIT) && i_OUT_READY) ||
                ((state == S_IN_WAIT)  && i_IN_VALID);
    // The counter reads k-1 during the k-th WAIT cycle; 17 bits avoid overflow.
    wait_last = (({1'b0, wait_cnt} + 17'd1) == {1'b0, TIMEOUT_CYCLES});
    // A handshake on the final WAIT cycle wins over the timeout.
    expire    = in_wait && !handshake && (TIMEOUT_CYCLES != 16'd0) && wait_last;
  end

  // Next-state decode and the combinational stall.
  always_comb begin
    // NOTE: every output of this block is given a default first so that no
    // path through the case statement can infer a latch.
    state_next = state;
    o_STALL    = 1'b0;
    case (state)
      S_IDLE: begin
        o_STALL = i_IOPAUSE;
        if (i_IOPAUSE) begin
          state_next = i_IOTYPE ? S_IN_WAIT : S_OUT_WAIT;
        end
      end
      S_OUT_WAIT, S_IN_WAIT: begin
        o_STALL = 1'b1;
        if (handshake || expire) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        // The CPU commits this cycle; i_IOPAUSE is deliberately ignored.
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (!i_RESET_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered channel strobes and the IN write qualifier.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      o_OUT_VALID   <= 1'b0;
      o_IN_READY    <= 1'b0;
      o_REGWRITE_EN <= 1'b0;
    end else begin
      o_OUT_VALID   <= (state_next == S_OUT_WAIT);
      o_IN_READY    <= (state_next == S_IN_WAIT);
      o_REGWRITE_EN <= (state == S_IN_WAIT) && (state_next == S_DONE);
    end
  end

  // Data capture: the OUT word at launch and the IN word (or zero on timeout).
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    // NOTE: these datapath registers are reset as well, because software
    // can observe them and they must read zero after reset.
    if (!i_RESET_N) begin
      o_OUT_DATA <= 16'h0000;
      o_INDATA   <= 16'h0000;
    end else begin
      if ((state == S_IDLE) && (state_next == S_OUT_WAIT)) begin
        o_OUT_DATA <= i_OUTDATA;
      end
      if (state == S_IN_WAIT) begin
        if (handshake) begin
          o_INDATA <= i_IN_DATA;
        end else if (expire) begin
          o_INDATA <= 16'h0000;
        end
      end
    end
  end

  // Wait counter: cleared on WAIT entry; saturating count of idle WAIT cycles.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      wait_cnt <= 16'h0000;
    end else if ((state == S_IDLE) && i_IOPAUSE) begin
      wait_cnt <= 16'h0000;
    end else if (in_wait && !handshake && (wait_cnt != 16'hFFFF)) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      o_TIMEOUT <= 1'b0;
    end else if (expire) begin
      o_TIMEOUT <= 1'b1;
    end else if (i_CLRERR) begin
      o_TIMEOUT <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_controller.sv
// Testbench for io_controller (TIMEOUT_CYCLES = 4). The reference model
// reasons per transaction: a device that stays silent for d WAIT cycles
// needs min(d+1, 4) WAIT cycles. The stall lasts one cycle longer than that,
// followed by exactly one DONE cycle.
module tb_io_controller;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        iopause;
  logic        iotype;
  logic [15:0] outdata;
  logic        stall;
  logic        regwrite;
  logic [15:0] indata;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        timeout;
  logic        clrerr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          stall_cyc;
    int          ov_cyc;
    int          ir_cyc;
    int          rw_cyc;
    logic [15:0] out_data;
    logic [15:0] in_data;
    logic        to;
  } obs_t;

  io_controller #(.TIMEOUT_CYCLES(16'd4)) dut (
    .i_CLK         (clk),
    .i_RESET_N     (rst_n),
    .i_IOPAUSE     (iopause),
    .i_IOTYPE      (iotype),
    .i_OUTDATA     (outdata),
    .o_STALL       (stall),
    .o_REGWRITE_EN (regwrite),
    .o_INDATA      (indata),
    .o_OUT_VALID   (out_valid),
    .o_OUT_DATA    (out_data),
    .i_OUT_READY   (out_ready),
    .i_IN_VALID    (in_valid),
    .i_IN_DATA     (in_data),
    .o_IN_READY    (in_ready),
    .o_TIMEOUT     (timeout),
    .i_CLRERR      (clrerr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: number of WAIT cycles for a device that stays silent for 'delay' cycles.
  function automatic int exp_waits(input int delay);
    return (delay + 1 < TMO) ? delay + 1 : TMO;
  endfunction

  // Drives one IN/OUT instruction and records what the DUT did, up to and
  // including the first cycle in which the stall drops (DONE).
  task automatic run_txn(input bit is_in, input logic [15:0] word, input int delay,
                         input bit clr, output obs_t o);
    bit dev;
    o = '{default: '0};
    @(posedge clk); #1;
    for (int c = 0; c < 64; c++) begin
      dev       = (c > delay) || (delay == 0);
      iopause   = 1'b1;
      iotype    = is_in;
      clrerr    = clr;
      outdata   = (is_in || c > 0) ? 16'($urandom) : word;
      in_data   = is_in ? word : 16'($urandom);
      in_valid  = is_in ? dev : 1'($urandom_range(0, 1));
      out_ready = is_in ? 1'($urandom_range(0, 1)) : dev;
      #1;
      if (stall === 1'b1)     o.stall_cyc++;
      if (out_valid === 1'b1) o.ov_cyc++;
      if (in_ready === 1'b1)  o.ir_cyc++;
      if (regwrite === 1'b1)  o.rw_cyc++;
      if (c > 0 && stall !== 1'b1) begin
        o.out_data = out_data;
        o.in_data  = indata;
        o.to       = timeout;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      iopause   = 1'b0;
      clrerr    = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    iopause   = 1'b0;
    iotype    = 1'b0;
    clrerr    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    iopause = 1'b1;
    #2;
    total++;
    if ({stall, out_valid, in_ready, regwrite, timeout} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=10000", {stall, out_valid, in_ready, regwrite, timeout});
    end
    total++;
    if ({out_data, indata} !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got=%h want=00000000", {out_data, indata});
    end
    iopause = 1'b0;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall_follow got=%b want=0", stall);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({stall, out_valid, in_ready, regwrite, timeout} !== 5'b00000) begin
      bad++;
      $display("FAIL post_reset_idle got=%b want=00000", {stall, out_valid, in_ready, regwrite, timeout});
    end
  endtask

  task automatic test_out_basic();
    obs_t o;
    run_txn(1'b0, 16'h1234, 2, 1'b0, o);
    total++;
    if (o.stall_cyc !== 4) begin
      bad++; $display("FAIL out_stall got=%0d want=4", o.stall_cyc);
    end
    total++;
    if (o.ov_cyc !== 3 || o.ir_cyc !== 0) begin
      bad++; $display("FAIL out_valid_cycles got=%0d/%0d want=3/0", o.ov_cyc, o.ir_cyc);
    end
    total++;
    if (o.rw_cyc !== 0) begin
      bad++; $display("FAIL out_regwrite got=%0d want=0", o.rw_cyc);
    end
    total++;
    if (o.out_data !== 16'h1234 || o.to !== 1'b0) begin
      bad++; $display("FAIL out_data got=%h/%b want=1234/0", o.out_data, o.to);
    end
    idle_cycles(1);
  endtask

  task automatic test_in_basic();
    obs_t o;
    run_txn(1'b1, 16'hBEEF, 0, 1'b0, o);
    total++;
    if (o.stall_cyc !== 2) begin
      bad++; $display("FAIL in_stall got=%0d want=2", o.stall_cyc);
    end
    total++;
    if (o.ir_cyc !== 1 || o.ov_cyc !== 0) begin
      bad++; $display("FAIL in_ready_cycles got=%0d/%0d want=1/0", o.ir_cyc, o.ov_cyc);
    end
    total++;
    if (o.rw_cyc !== 1) begin
      bad++; $display("FAIL in_regwrite got=%0d want=1", o.rw_cyc);
    end
    total++;
    if (o.in_data !== 16'hBEEF) begin
      bad++; $display("FAIL in_data got=%h want=beef", o.in_data);
    end
    idle_cycles(1);
    total++;
    if (regwrite !== 1'b0) begin
      bad++; $display("FAIL in_regwrite_after got=%b want=0", regwrite);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(1'b1, 16'h5A5A, 100, 1'b0, o);
    total++;
    if (o.stall_cyc !== 5 || o.ir_cyc !== 4) begin
      bad++; $display("FAIL tmo_in_cycles got=%0d/%0d want=5/4", o.stall_cyc, o.ir_cyc);
    end
    total++;
    if (o.rw_cyc !== 1 || o.in_data !== 16'h0000 || o.to !== 1'b1) begin
      bad++; $display("FAIL tmo_in_result got=%0d/%h/%b want=1/0000/1", o.rw_cyc, o.in_data, o.to);
    end
    idle_cycles(3);
    total++;
    if (timeout !== 1'b1) begin
      bad++; $display("FAIL tmo_sticky got=%b want=1", timeout);
    end
    clrerr = 1'b1;
    @(posedge clk); #1 clrerr = 1'b0;
    #1;
    total++;
    if (timeout !== 1'b0) begin
      bad++; $display("FAIL tmo_clear got=%b want=0", timeout);
    end
    // Clear held high across the whole transaction: the timeout edge must still set.
    run_txn(1'b0, 16'h7777, 100, 1'b1, o);
    total++;
    if (o.stall_cyc !== 5 || o.ov_cyc !== 4 || o.rw_cyc !== 0) begin
      bad++; $display("FAIL tmo_out_cycles got=%0d/%0d/%0d want=5/4/0", o.stall_cyc, o.ov_cyc, o.rw_cyc);
    end
    total++;
    if (o.to !== 1'b1 || o.out_data !== 16'h7777) begin
      bad++; $display("FAIL tmo_set_wins got=%b/%h want=1/7777", o.to, o.out_data);
    end
    @(posedge clk); #1 iopause = 1'b0;
    #1;
    total++;
    if (timeout !== 1'b0) begin
      bad++; $display("FAIL tmo_clear_after got=%b want=0", timeout);
    end
    idle_cycles(1);
  endtask

  task automatic test_boundary();
    obs_t o;
    run_txn(1'b0, 16'hC3C3, 3, 1'b0, o);
    total++;
    if (o.stall_cyc !== 5 || o.ov_cyc !== 4) begin
      bad++; $display("FAIL edge_out_cycles got=%0d/%0d want=5/4", o.stall_cyc, o.ov_cyc);
    end
    total++;
    if (o.to !== 1'b0 || o.out_data !== 16'hC3C3) begin
      bad++; $display("FAIL edge_out_result got=%b/%h want=0/c3c3", o.to, o.out_data);
    end
    run_txn(1'b1, 16'h9E37, 3, 1'b0, o);
    total++;
    if (o.stall_cyc !== 5 || o.rw_cyc !== 1) begin
      bad++; $display("FAIL edge_in_cycles got=%0d/%0d want=5/1", o.stall_cyc, o.rw_cyc);
    end
    total++;
    if (o.to !== 1'b0 || o.in_data !== 16'h9E37) begin
      bad++; $display("FAIL edge_in_result got=%b/%h want=0/9e37", o.to, o.in_data);
    end
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    obs_t a;
    obs_t b;
    run_txn(1'b1, 16'h0001, 0, 1'b0, a);
    run_txn(1'b1, 16'h0002, 0, 1'b0, b);
    total++;
    if (a.stall_cyc !== 2 || a.rw_cyc !== 1 || a.in_data !== 16'h0001) begin
      bad++; $display("FAIL b2b_first got=%0d/%0d/%h want=2/1/0001", a.stall_cyc, a.rw_cyc, a.in_data);
    end
    total++;
    if (b.stall_cyc !== 2 || b.rw_cyc !== 1 || b.in_data !== 16'h0002) begin
      bad++; $display("FAIL b2b_second got=%0d/%0d/%h want=2/1/0002", b.stall_cyc, b.rw_cyc, b.in_data);
    end
    idle_cycles(1);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    @(posedge clk); #1;
    iopause = 1'b1; iotype = 1'b0; outdata = 16'hAAAA; out_ready = 1'b0; in_valid = 1'b0;
    @(posedge clk); #2;
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL mid_in_wait got=%b want=1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({stall, out_valid, in_ready, regwrite, timeout} !== 5'b10000 || {out_data, indata} !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset got=%b/%h want=10000/00000000",
               {stall, out_valid, in_ready, regwrite, timeout}, {out_data, indata});
    end
    iopause = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_txn(1'b0, 16'h00FF, 1, 1'b0, o);
    total++;
    if (o.stall_cyc !== 3 || o.ov_cyc !== 2 || o.rw_cyc !== 0 || o.out_data !== 16'h00FF) begin
      bad++;
      $display("FAIL mid_recover got=%0d/%0d/%0d/%h want=3/2/0/00ff", o.stall_cyc, o.ov_cyc, o.rw_cyc, o.out_data);
    end
    idle_cycles(1);
  endtask

  task automatic test_random();
    obs_t        o;
    logic [15:0] exp_in;
    logic [15:0] exp_out;
    logic        exp_to;
    bit          is_in;
    bit          any_clr;
    logic [15:0] word;
    int          delay;
    int          n;
    do_reset();
    exp_in  = 16'h0000;
    exp_out = 16'h0000;
    exp_to  = 1'b0;
    for (int t = 0; t < 40; t++) begin
      any_clr = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        iopause   = 1'b0;
        clrerr    = 1'($urandom_range(0, 1));
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        if (clrerr) any_clr = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0 || regwrite !== 1'b0) begin
          bad++; $display("FAIL rnd_gap t=%0d got=%b%b want=00", t, stall, regwrite);
        end
      end
      if (any_clr) exp_to = 1'b0;
      is_in = 1'($urandom_range(0, 1));
      word  = 16'($urandom);
      delay = $urandom_range(0, 6);
      n     = exp_waits(delay);
      if (delay + 1 > TMO) exp_to = 1'b1;
      if (is_in) exp_in = (delay + 1 > TMO) ? 16'h0000 : word;
      else       exp_out = word;
      run_txn(is_in, word, delay, 1'b0, o);
      total++;
      if (o.stall_cyc !== n + 1) begin
        bad++; $display("FAIL rnd_stall t=%0d got=%0d want=%0d", t, o.stall_cyc, n + 1);
      end
      total++;
      if (o.ov_cyc !== (is_in ? 0 : n) || o.ir_cyc !== (is_in ? n : 0)) begin
        bad++; $display("FAIL rnd_chan t=%0d got=%0d/%0d want=%0d/%0d", t, o.ov_cyc, o.ir_cyc,
                        is_in ? 0 : n, is_in ? n : 0);
      end
      total++;
      if (o.rw_cyc !== (is_in ? 1 : 0)) begin
        bad++; $display("FAIL rnd_regwrite t=%0d got=%0d want=%0d", t, o.rw_cyc, is_in ? 1 : 0);
      end
      total++;
      if (o.in_data !== exp_in) begin
        bad++; $display("FAIL rnd_indata t=%0d got=%h want=%h", t, o.in_data, exp_in);
      end
      total++;
      if (o.out_data !== exp_out) begin
        bad++; $display("FAIL rnd_outdata t=%0d got=%h want=%h", t, o.out_data, exp_out);
      end
      total++;
      if (o.to !== exp_to) begin
        bad++; $display("FAIL rnd_timeout t=%0d got=%b want=%b", t, o.to, exp_to);
      end
    end
    idle_cycles(2);
  endtask

  initial begin
    rst_n     = 1'b1;
    iopause   = 1'b0;
    iotype    = 1'b0;
    outdata   = 16'h0000;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    clrerr    = 1'b0;
    #1 rst_n = 1'b0;
    test_reset();
    test_out_basic();
    test_in_basic();
    test_timeout();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
